// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the sync-read instruction memory, fills the IF/ID register.
// Latency: 2 edges from address presentation to IF/ID; one instruction per cycle in steady state.
// Backpressure: stall freezes PC and IF/ID (memory re-reads the same word); redirect overrides stall.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus1,
  output logic                  if_valid,
  output logic [31:0]           instr_count
);

  // pc_q is the address whose word is currently on imem_data; fv_q says that word is real.
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fv_q, fv_d;
  logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           instr_count_q, instr_count_d;
  logic [ADDR_WIDTH-1:0] addr_sel;

  // Next fetch address: redirect beats stall; stall and startup re-read pc_q so imem_data stays put.
  always_comb begin
    addr_sel = pc_q + ADDR_WIDTH'(1);
    if (!rst_n) begin
      addr_sel = RESET_PC;
    end else if (redirect) begin
      addr_sel = redirect_addr;
    end else if (stall || !fv_q) begin
      addr_sel = pc_q;
    end
    pc_d = addr_sel;
    fv_d = 1'b1;
  end

  // IF/ID next state: redirect squashes the in-flight wrong-path word, stall holds, else load.
  always_comb begin
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_valid_d    = if_valid_q;
    instr_count_d = instr_count_q;
    if (redirect) begin
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if_instr_d = fv_q ? imem_data : '0;
      if_pc_d    = pc_q;
      if_valid_d = fv_q;
      if (fv_q) begin
        instr_count_d = instr_count_q + 32'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      fv_q          <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fv_q          <= fv_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign imem_addr   = addr_sel;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus1 = if_pc_q + ADDR_WIDTH'(1);
  assign if_valid    = if_valid_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle sync-read memory holding 0xA0000000+addr.
// Each scenario task drives inputs #1 after a rising edge and checks outputs at that same point.
// IF/ID is compared as one packed {valid, pc, instr} vector per cycle.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [9:0]  redirect_addr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic [9:0]  if_pc_plus1;
  logic        if_valid;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;

  instruction_fetch #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .RESET_PC(10'd0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc_plus1(if_pc_plus1),
    .if_valid(if_valid),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_data <= 32'hA000_0000 + {22'd0, imem_addr};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [42:0] ifid(input logic v, input logic [9:0] pc, input logic [31:0] ins);
    return {v, pc, ins};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [42:0] exp;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    #3;
    exp = ifid(1'b0, 10'd0, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd0 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got ifid=%h cnt=%0d addr=%h, want ifid=%h cnt=0 addr=000",
               {if_valid, if_pc, if_instr}, instr_count, imem_addr, exp);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Assumes reset was just released between edges.
  task automatic test_startup();
    logic [42:0] exp;
    step();
    exp = ifid(1'b0, 10'd0, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL startup_edge1: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    step();
    exp = ifid(1'b1, 10'd0, 32'hA000_0000);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd1) begin
      errors++;
      $display("FAIL startup_edge2: got %h cnt=%0d want %h cnt=1", {if_valid, if_pc, if_instr}, instr_count, exp);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = ifid(1'b1, 10'(k), 32'hA000_0000 + 32'(k));
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp || if_pc_plus1 !== 10'(k + 1)) begin
        errors++;
        $display("FAIL startup_seq%0d: got %h plus1=%h want %h plus1=%h",
                 k, {if_valid, if_pc, if_instr}, if_pc_plus1, exp, 10'(k + 1));
      end
    end
    checks++;
    if (instr_count !== 32'd5) begin
      errors++;
      $display("FAIL startup_count: got %0d want 5", instr_count);
    end
  endtask

  // Continues from test_startup (if_pc=4, count=5).
  task automatic test_stall();
    logic [42:0] exp;
    step();
    exp = ifid(1'b1, 10'd5, 32'hA000_0005);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd6) begin
      errors++;
      $display("FAIL stall_pre: got %h cnt=%0d want %h cnt=6", {if_valid, if_pc, if_instr}, instr_count, exp);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd6) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h cnt=%0d want %h cnt=6", k, {if_valid, if_pc, if_instr}, instr_count, exp);
      end
    end
    stall = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      step();
      exp = ifid(1'b1, 10'(k), 32'hA000_0000 + 32'(k));
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'(k + 1)) begin
        errors++;
        $display("FAIL stall_resume%0d: got %h cnt=%0d want %h cnt=%0d",
                 k, {if_valid, if_pc, if_instr}, instr_count, exp, k + 1);
      end
    end
  endtask

  task automatic test_stall_startup();
    logic [42:0] exp;
    do_reset();
    stall = 1'b1;
    step();
    step();
    exp = ifid(1'b0, 10'd0, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL stall_startup_hold: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    stall = 1'b0;
    step();
    exp = ifid(1'b1, 10'd0, 32'hA000_0000);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd1) begin
      errors++;
      $display("FAIL stall_startup_first: got %h cnt=%0d want %h cnt=1", {if_valid, if_pc, if_instr}, instr_count, exp);
    end
    step();
    exp = ifid(1'b1, 10'd1, 32'hA000_0001);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL stall_startup_second: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
  endtask

  task automatic test_redirect();
    logic [42:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    exp = ifid(1'b1, 10'd3, 32'hA000_0003);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL redirect_pre: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    redirect = 1'b1;
    redirect_addr = 10'h100;
    step();
    redirect = 1'b0;
    exp = ifid(1'b0, 10'd3, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd4) begin
      errors++;
      $display("FAIL redirect_bubble: got %h cnt=%0d want %h cnt=4", {if_valid, if_pc, if_instr}, instr_count, exp);
    end
    step();
    exp = ifid(1'b1, 10'h100, 32'hA000_0100);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || instr_count !== 32'd5) begin
      errors++;
      $display("FAIL redirect_target: got %h cnt=%0d want %h cnt=5", {if_valid, if_pc, if_instr}, instr_count, exp);
    end
    step();
    exp = ifid(1'b1, 10'h101, 32'hA000_0101);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL redirect_next: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
  endtask

  // Continues from test_redirect (if_pc=0x101).
  task automatic test_redirect_stall();
    logic [42:0] exp;
    redirect = 1'b1;
    stall = 1'b1;
    redirect_addr = 10'h020;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    exp = ifid(1'b0, 10'h101, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL redir_stall_bubble: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    step();
    exp = ifid(1'b1, 10'h020, 32'hA000_0020);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL redir_stall_target: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
  endtask

  // Continues from test_redirect_stall (if_pc=0x020).
  task automatic test_wrap();
    logic [42:0] exp;
    redirect = 1'b1;
    redirect_addr = 10'h3FF;
    step();
    redirect = 1'b0;
    exp = ifid(1'b0, 10'h020, 32'd0);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL wrap_bubble: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    step();
    exp = ifid(1'b1, 10'h3FF, 32'hA000_03FF);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp || if_pc_plus1 !== 10'h000) begin
      errors++;
      $display("FAIL wrap_top: got %h plus1=%h want %h plus1=000", {if_valid, if_pc, if_instr}, if_pc_plus1, exp);
    end
    step();
    exp = ifid(1'b1, 10'h000, 32'hA000_0000);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL wrap_zero: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
    step();
    exp = ifid(1'b1, 10'h001, 32'hA000_0001);
    checks++;
    if ({if_valid, if_pc, if_instr} !== exp) begin
      errors++;
      $display("FAIL wrap_one: got %h want %h", {if_valid, if_pc, if_instr}, exp);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_valid, if_pc, if_instr} !== 43'd0 || instr_count !== 32'd0 || imem_addr !== 10'd0) begin
      errors++;
      $display("FAIL midrun_reset: got ifid=%h cnt=%0d addr=%h, want all zero",
               {if_valid, if_pc, if_instr}, instr_count, imem_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_stall_startup();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
